dlatch_bank_sched: RTL and testbench
====================================

Name: dlatch_bank_sched

Overview:
- Time-shares one DW-bit bank of level-sensitive D latches (gate-level NAND/NOR latch cells) between NREQ requesters.
- Round-robin arbitration, then sequences each write as data setup → gate open → data hold.
- The latch gate is therefore only pulsed with stable data, avoiding transparency races.
- Reads back the latch outputs after each write and flags mismatches.

Parameters:
- NREQ, 4, number of requesters (≥2).
- DW, 8, latch bank data width (≥1).
- SETUP_CYC, 1, cycles data is driven before gate opens (≥1).
- OPEN_CYC, 2, cycles latch_en is high (≥1).
- HOLD_CYC, 1, cycles data is held after gate closes (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester write request, level; held until its done.
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW].
- grant  out  NREQ  one-hot, high for requester owning the bank.
- done  out  NREQ  one-cycle pulse to the owner at transaction end.
- wr_err  out  1  one-cycle pulse with done when readback mismatches.
- latch_d  out  DW  data to latch bank D inputs.
- latch_en  out  1  latch gate (transparent when high).
- latch_q  in  DW  latch bank Q outputs (readback).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - grant=0, done=0, wr_err=0, latch_d=0, latch_en=0, busy=0.
  - state=IDLE, rr pointer=0, phase counter=0.
  - latch_en must drop without waiting for clk.
- States: IDLE, SETUP, OPEN, HOLD. All outputs are registered.
- IDLE:
  - If any req is high, pick the first requester at or after the rr pointer (circular), lowest index wins ties.
  - Capture its req_data into latch_d, set grant one-hot, enter SETUP.
  - If no req, stay in IDLE. latch_d keeps the last written value.
- SETUP: lasts SETUP_CYC cycles, latch_en=0, then enter OPEN.
- OPEN: lasts OPEN_CYC cycles, latch_en=1, then enter HOLD.
- HOLD:
  - Lasts HOLD_CYC cycles, latch_en=0, latch_d unchanged.
  - On the final HOLD cycle, done[owner] and wr_err (if latch_q≠latch_d) are asserted for exactly one cycle at the next edge.
  - grant drops at that same edge.
- Throughput: a transaction occupies SETUP_CYC+OPEN_CYC+HOLD_CYC cycles. Defaults give 4 cycles: req sampled at edge 0, grant at edge 1, latch_en high after edges 2–3, done high after edge 5.
- Back-to-back:
  - On leaving HOLD, if any req other than the finishing owner is high, arbitrate immediately and enter SETUP with the new grant.
  - No IDLE bubble in that case; done of the old owner and grant of the new owner are in the same cycle.
  - If only the finishing owner's req is high, the scheduler returns to IDLE for one cycle before re-arbitrating. The owner must drop req on done to avoid a double write.
- rr pointer updates to (owner+1) mod NREQ when a grant is issued.
- req deassert mid-transaction: ignored; the write completes and done still pulses.
- req_data changes after capture: ignored; latch_d holds the captured value until the next grant.
- latch_d and grant never change while latch_en=1.
- latch_en is never high in two consecutive transactions without at least SETUP_CYC+HOLD_CYC low cycles between them.
- Phase counter width: clog2 of max(SETUP_CYC, OPEN_CYC, HOLD_CYC)+1. It reloads on every state entry.
- Reset asserted mid-OPEN: latch_en falls asynchronously, the transaction is abandoned, and no done is issued. After release, arbitration restarts from requester 0.

Test Plan:
- Single write, defaults: req=4'b0010, req_data[15:8]=8'hA5, latch_q tied to latch_d → grant=0010 one cycle later; latch_d=A5; latch_en high exactly 2 cycles; done=0010 one pulse 4 cycles after grant; wr_err=0.
- Round-robin fairness: req=4'b1111 held, each requester dropping req on its done → grants in order 0001, 0010, 0100, 1000, back-to-back. The next grant follows each done in the same cycle; exactly 4 latch_en pulses.
- Readback error: req=4'b0001, data 8'h3C, latch_q forced to 8'h00 → done[0] and wr_err pulse together; latch_d stays 3C afterwards.
- Data instability: change req_data of the owner to 8'hFF during OPEN → latch_d stays the captured value throughout; latch_en width still OPEN_CYC.
- Async reset mid-OPEN: assert rst between clock edges while latch_en=1 → latch_en, grant and latch_d go 0 before the next edge; no done. After release with req=4'b0100, grant=0100.
- Parameter sweep: SETUP_CYC=3, OPEN_CYC=1, HOLD_CYC=2 → 3 low, 1 high, 2 low latch_en cycles per transaction; done 6 cycles after grant.

Source files
------------

// File: rtl/dlatch_bank_sched.sv
// dlatch_bank_sched
//   Shares one DW-bit bank of level-sensitive D latches between NREQ
//   requesters. A round-robin arbiter picks an owner, and the write is then
//   sequenced as data setup -> gate open -> data hold. The gate is only
//   pulsed while latch_d is stable. The latch outputs are read back at the
//   end of each write, and any mismatch is flagged.
//
// Ports
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   req        per-requester write request (level, held until done)
//   req_data   requester i data at [i*DW +: DW]
//   grant      one-hot owner of the bank
//   done       one-cycle pulse to the owner at transaction end
//   wr_err     one-cycle pulse with done on readback mismatch
//   latch_d    latch bank D inputs
//   latch_en   latch gate (transparent when high)
//   latch_q    latch bank Q outputs (readback)
//   busy       high whenever the scheduler is not idle
module dlatch_bank_sched #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               wr_err,
  output logic [DW-1:0]      latch_d,
  output logic               latch_en,
  input  logic [DW-1:0]      latch_q,
  output logic               busy
);

  localparam int RW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAX1 = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int MAXC = (MAX1 > HOLD_CYC) ? MAX1 : HOLD_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t          state;
  logic [RW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] pick_oh;
  logic [RW-1:0]   pick_idx;
  logic [RW-1:0]   idx;
  logic [RW-1:0]   rr_nxt;
  logic            pick_vld;

  // Round-robin pick. While leaving HOLD the finishing owner is masked so a
  // requester that has not yet dropped req cannot be granted twice in a row.
  // The scan runs from the far end back toward rr_ptr. Each hit overwrites
  // the previous one, so the last hit is the first requester at or after
  // rr_ptr.
  always_comb begin
    arb_req  = (state == HOLD) ? (req & ~grant) : req;
    pick_idx = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = RW'((int'(rr_ptr) + k) % NREQ);
      if (arb_req[idx]) begin
        pick_idx = idx;
        pick_vld = 1'b1;
      end
    end
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
    rr_nxt = (pick_idx == RW'(NREQ - 1)) ? '0 : pick_idx + RW'(1);
  end

  // The phase counter is loaded with (length-1) on state entry. The state
  // advances when the counter reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      grant    <= '0;
      done     <= '0;
      wr_err   <= 1'b0;
      latch_d  <= '0;
      latch_en <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done   <= '0;
      wr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant   <= pick_oh;
            rr_ptr  <= rr_nxt;
            latch_d <= req_data[pick_idx*DW +: DW];
            cnt     <= CW'(SETUP_CYC - 1);
            state   <= SETUP;
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt      <= CW'(OPEN_CYC - 1);
            state    <= OPEN;
            latch_en <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        OPEN: begin
          if (cnt == '0) begin
            cnt      <= CW'(HOLD_CYC - 1);
            state    <= HOLD;
            latch_en <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            done   <= grant;
            wr_err <= (latch_q != latch_d);
            // Hand over with no idle bubble when another requester waits.
            if (pick_vld) begin
              grant   <= pick_oh;
              rr_ptr  <= rr_nxt;
              latch_d <= req_data[pick_idx*DW +: DW];
              cnt     <= CW'(SETUP_CYC - 1);
              state   <= SETUP;
            end else begin
              grant <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          latch_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlatch_bank_sched.sv
module tb_dlatch_bank_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant, done;
  logic        wr_err, latch_en, busy;
  logic [7:0]  latch_d, latch_q;
  logic        q_force;

  // Second instance for the timing parameter sweep
  logic [3:0]  req2;
  logic [31:0] req_data2;
  logic [3:0]  grant2, done2;
  logic        wr_err2, latch_en2, busy2;
  logic [7:0]  latch_d2, latch_q2;

  int n_vec = 0;
  int n_err = 0;

  assign latch_q  = q_force ? 8'h00 : latch_d;
  assign latch_q2 = latch_d2;

  dlatch_bank_sched dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .done(done), .wr_err(wr_err), .latch_d(latch_d), .latch_en(latch_en),
    .latch_q(latch_q), .busy(busy)
  );

  dlatch_bank_sched #(.SETUP_CYC(3), .OPEN_CYC(1), .HOLD_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .grant(grant2),
    .done(done2), .wr_err(wr_err2), .latch_d(latch_d2), .latch_en(latch_en2),
    .latch_q(latch_q2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d [4];
    rst = 1'b1; req = '0; req_data = '0; q_force = 1'b0;
    req2 = '0; req_data2 = '0;
    tick;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_latch_d", latch_d, 0);
    chk("rst_latch_en", latch_en, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick;

    // Single write
    req = 4'b0010; req_data = {8'h83, 8'h42, 8'hA5, 8'h10};
    tick;
    chk("t1_grant", grant, 4'b0010);
    chk("t1_latch_d", latch_d, 8'hA5);
    chk("t1_en_setup", latch_en, 0);
    chk("t1_busy", busy, 1);
    tick; chk("t1_en_open0", latch_en, 1);
    tick; chk("t1_en_open1", latch_en, 1);
    tick; chk("t1_en_hold", latch_en, 0);
    chk("t1_done_early", done, 0);
    tick;
    chk("t1_done", done, 4'b0010);
    chk("t1_wr_err", wr_err, 0);
    chk("t1_grant_drop", grant, 0);
    req = '0;
    tick;
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", busy, 0);

    // Round robin, back to back. Reset first so the pointer starts at 0.
    rst = 1'b1; tick; rst = 1'b0; tick;
    d[0] = 8'h10; d[1] = 8'h21; d[2] = 8'h42; d[3] = 8'h83;
    req_data = {d[3], d[2], d[1], d[0]};
    req = 4'b1111;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_grant%0d", k), grant, 4'b0001 << k);
      chk($sformatf("rr_data%0d", k), latch_d, d[k]);
      chk($sformatf("rr_en_setup%0d", k), latch_en, 0);
      tick; chk($sformatf("rr_en_a%0d", k), latch_en, 1);
      tick; chk($sformatf("rr_en_b%0d", k), latch_en, 1);
      tick; chk($sformatf("rr_en_hold%0d", k), latch_en, 0);
      tick; chk($sformatf("rr_done%0d", k), done, 4'b0001 << k);
      req[k] = 1'b0;
    end
    chk("rr_final_grant", grant, 0);
    tick;
    chk("rr_final_busy", busy, 0);

    // Readback error
    q_force = 1'b1;
    req = 4'b0001; req_data = {8'h00, 8'h00, 8'h00, 8'h3C};
    tick;
    chk("err_grant", grant, 4'b0001);
    tick; tick; tick;
    tick;
    chk("err_done", done, 4'b0001);
    chk("err_wr_err", wr_err, 1);
    req = '0;
    tick;
    chk("err_pulse", wr_err, 0);
    chk("err_latch_d", latch_d, 8'h3C);
    q_force = 1'b0;

    // Data instability during OPEN
    req = 4'b0010; req_data = {8'h00, 8'h00, 8'hB7, 8'h00};
    tick;
    chk("inst_grant", grant, 4'b0010);
    chk("inst_d0", latch_d, 8'hB7);
    tick;
    req_data = {8'h00, 8'h00, 8'hFF, 8'h00};
    chk("inst_en0", latch_en, 1);
    tick;
    chk("inst_en1", latch_en, 1);
    chk("inst_d1", latch_d, 8'hB7);
    tick;
    chk("inst_en2", latch_en, 0);
    chk("inst_d2", latch_d, 8'hB7);
    tick;
    chk("inst_done", done, 4'b0010);
    chk("inst_wr_err", wr_err, 0);
    chk("inst_d3", latch_d, 8'hB7);
    req = '0;
    tick;

    // Async reset mid-OPEN
    req = 4'b0100; req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
    tick;
    chk("ar_grant", grant, 4'b0100);
    tick;
    chk("ar_en", latch_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_en_async", latch_en, 0);
    chk("ar_grant_async", grant, 0);
    chk("ar_latch_d_async", latch_d, 0);
    tick;
    chk("ar_no_done", done, 0);
    rst = 1'b0;
    tick;
    chk("ar_regrant", grant, 4'b0100);
    chk("ar_relatch", latch_d, 8'h5A);
    tick; tick; tick;
    chk("ar_done_early", done, 0);
    tick;
    chk("ar_done", done, 4'b0100);
    req = '0;
    tick;

    // Timing sweep: SETUP 3, OPEN 1, HOLD 2
    req2 = 4'b0001; req_data2 = {8'h00, 8'h00, 8'h00, 8'h77};
    tick;
    chk("sw_grant", grant2, 4'b0001);
    chk("sw_latch_d", latch_d2, 8'h77);
    chk("sw_en_s0", latch_en2, 0);
    tick; chk("sw_en_s1", latch_en2, 0);
    tick; chk("sw_en_s2", latch_en2, 0);
    tick; chk("sw_en_o0", latch_en2, 1);
    tick; chk("sw_en_h0", latch_en2, 0);
    tick; chk("sw_en_h1", latch_en2, 0);
    chk("sw_done_early", done2, 0);
    tick;
    chk("sw_done", done2, 4'b0001);
    chk("sw_wr_err", wr_err2, 0);
    req2 = '0;
    tick;
    chk("sw_idle", busy2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
